// File: rtl/redmule_pkg.sv
// -----------------------------------------------------------------------------
// redmule_pkg
// Shared types and constants for the RedMulE W ping-pong buffer.
//   ARRAY_HEIGHT / PIPE_REGS : default engine geometry
//   w_pp_bank_state_e        : per-bank life cycle (empty -> filling -> full -> reading)
//   w_pp_ctrl_t              : tile programming latched on a bank's first row
//   w_pp_flags_t             : handshake/status flags of the buffer
//   ring_next()              : increment a ring pointer modulo a bank count
// -----------------------------------------------------------------------------
package redmule_pkg;

    localparam int unsigned ARRAY_HEIGHT = 4;
    localparam int unsigned PIPE_REGS    = 3;

    typedef enum logic [1:0] {
        W_PP_EMPTY   = 2'd0,
        W_PP_FILLING = 2'd1,
        W_PP_FULL    = 2'd2,
        W_PP_READING = 2'd3
    } w_pp_bank_state_e;

    // Fields are sized generously so the struct works for any geometry;
    // narrower ports are zero-extended into it.
    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [7:0]  reps;
    } w_pp_ctrl_t;

    typedef struct packed {
        logic w_ready;
        logic out_valid;
        logic bank_done;
    } w_pp_flags_t;

    function automatic int unsigned ring_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/redmule_w_pp_bank.sv
// -----------------------------------------------------------------------------
// redmule_w_pp_bank
// Storage for one W tile: HEIGHT rows of D = DW/BITW elements.
//   clk_i      : clock
//   we_i       : write row row_i with w_data_i
//   row_i      : destination row
//   w_data_i   : incoming row, element d at bits [(d+1)*BITW-1 : d*BITW]
//   width_i    : elements d >= width_i are stored as zero
//   height_i   : rows r >= height_i are stored as zero
//   rd_idx_i   : column element to present (indices >= D read as zero)
//   rd_data_o  : element rd_idx_i of every row, row h at [(h+1)*BITW-1 : h*BITW]
// Stored data has no reset; only the control state around it does.
// -----------------------------------------------------------------------------
module redmule_w_pp_bank #(
    parameter int unsigned DW     = 288,
    parameter int unsigned BITW   = 16,
    parameter int unsigned HEIGHT = 4,
    parameter int unsigned ROW_W  = 2,
    parameter int unsigned IDX_W  = 5
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ROW_W-1:0]         row_i,
    input  logic [DW-1:0]            w_data_i,
    input  logic [15:0]              width_i,
    input  logic [15:0]              height_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [HEIGHT*BITW-1:0]   rd_data_o
);

    localparam int unsigned D  = DW / BITW;
    localparam int unsigned EW = (D > 1) ? $clog2(D) : 1;

    logic [BITW-1:0] mem_reg [HEIGHT][D];
    logic [D*BITW-1:0] wr_row;
    logic [EW-1:0]     rd_el;

    // Zero-pad mask applied on the way in, so reads never need the tile shape.
    for (genvar gi = 0; gi < D; gi++) begin : g_wmask
        assign wr_row[gi*BITW +: BITW] =
            (gi < int'(width_i) && int'(row_i) < int'(height_i)) ? w_data_i[gi*BITW +: BITW]
                                                                 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int d = 0; d < D; d++) begin
                mem_reg[row_i][d] <= wr_row[d*BITW +: BITW];
            end
        end
    end

    assign rd_el = rd_idx_i[EW-1:0];

    // The last column group may extend past D; those slots read as zero.
    always_comb begin
        rd_data_o = '0;
        if (int'(rd_idx_i) < D) begin
            for (int h = 0; h < HEIGHT; h++) begin
                rd_data_o[h*BITW +: BITW] = mem_reg[h][rd_el];
            end
        end
    end

endmodule

// File: rtl/redmule_w_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// redmule_w_pingpong_buffer
// N_BANKS ring-ordered W tile buffer: one bank fills from the streamer while
// another is replayed reps times into the PE array.
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear)
//   w_valid_i / w_ready_o / w_data_i : row write handshake
//   width_i, height_i, reps_i        : tile shape, latched on a bank's first row
//   shift_i                          : consume the current column element
//   out_valid_o, w_buffer_o          : current element of every row of the read bank
//   bank_done_o                      : one-cycle pulse after a bank is released
//   fill_bank_o, read_bank_o         : ring pointers
// -----------------------------------------------------------------------------
module redmule_w_pingpong_buffer
    import redmule_pkg::*;
#(
    parameter int unsigned DW      = 288,
    parameter int unsigned BITW    = 16,
    parameter int unsigned Height  = ARRAY_HEIGHT,
    parameter int unsigned N_REGS  = PIPE_REGS,
    parameter int unsigned N_BANKS = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              w_valid_i,
    output logic                              w_ready_o,
    input  logic [DW-1:0]                     w_data_i,
    input  logic [$clog2(DW/BITW):0]          width_i,
    input  logic [$clog2(Height):0]           height_i,
    input  logic [7:0]                        reps_i,
    input  logic                              shift_i,
    output logic                              out_valid_o,
    output logic [Height*BITW-1:0]            w_buffer_o,
    output logic                              bank_done_o,
    output logic [$clog2(N_BANKS)-1:0]        fill_bank_o,
    output logic [$clog2(N_BANKS)-1:0]        read_bank_o
);

    localparam int unsigned D     = DW / BITW;
    localparam int unsigned EPC   = N_REGS + 1;
    localparam int unsigned C     = (D + EPC - 1) / EPC;
    localparam int unsigned NSH   = C * EPC;
    localparam int unsigned PW    = $clog2(N_BANKS);
    localparam int unsigned ROW_W = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned EL_W  = (EPC > 1) ? $clog2(EPC) : 1;
    localparam int unsigned COL_W = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned IDX_W = (NSH > 1) ? $clog2(NSH) : 1;

    logic [PW-1:0]    fill_reg, fill_next;
    logic [PW-1:0]    rd_reg, rd_next;
    logic [ROW_W-1:0] w_row_reg, w_row_next;
    logic [EL_W-1:0]  el_reg, el_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [7:0]       pass_reg, pass_next;
    logic             bank_done_reg, bank_done_next;

    logic [N_BANKS-1:0] bank_empty;
    logic [N_BANKS-1:0] bank_writable;
    logic [N_BANKS-1:0] bank_readable;
    w_pp_ctrl_t         bank_ctrl [N_BANKS];
    logic [Height*BITW-1:0] bank_rd [N_BANKS];

    w_pp_flags_t flags;
    w_pp_ctrl_t  wr_ctrl;
    logic        wr_fire, sh_fire, row_last, last_shift, bank_release;
    logic [7:0]  reps_eff;
    logic [IDX_W-1:0] rd_idx;

    assign flags.w_ready   = bank_writable[fill_reg];
    assign flags.out_valid = bank_readable[rd_reg];
    assign flags.bank_done = bank_done_reg;

    assign wr_fire    = w_valid_i && flags.w_ready;
    assign sh_fire    = shift_i && flags.out_valid;
    assign row_last   = (w_row_reg == ROW_W'(Height - 1));
    assign last_shift = sh_fire && (el_reg == EL_W'(N_REGS)) && (col_reg == COL_W'(C - 1));
    assign reps_eff   = (bank_ctrl[rd_reg].reps == 8'd0) ? 8'd1 : bank_ctrl[rd_reg].reps;
    // Release happens on the last shift of the last pass.
    assign bank_release = last_shift && (pass_reg == reps_eff - 8'd1);
    assign rd_idx     = IDX_W'(32'(col_reg) * EPC + 32'(el_reg));

    // Shape used for masking: fresh inputs on the first row, latched ones after.
    always_comb begin
        wr_ctrl = bank_ctrl[fill_reg];
        if (bank_empty[fill_reg]) begin
            wr_ctrl.width  = 16'(width_i);
            wr_ctrl.height = 16'(height_i);
            wr_ctrl.reps   = reps_i;
        end
    end

    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
        w_pp_bank_state_e state_reg, state_next;
        w_pp_ctrl_t       ctrl_reg, ctrl_next;
        logic             wr_hit, rd_hit;

        assign wr_hit = wr_fire && (fill_reg == PW'(gi));
        assign rd_hit = sh_fire && (rd_reg == PW'(gi));

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                state_reg <= W_PP_EMPTY;
                ctrl_reg  <= '0;
            end else begin
                state_reg <= state_next;
                ctrl_reg  <= ctrl_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            ctrl_next  = ctrl_reg;
            case (state_reg)
                W_PP_EMPTY: begin
                    if (wr_hit) begin
                        ctrl_next  = wr_ctrl;
                        state_next = row_last ? W_PP_FULL : W_PP_FILLING;
                    end
                end
                W_PP_FILLING: begin
                    if (wr_hit && row_last) begin
                        state_next = W_PP_FULL;
                    end
                end
                W_PP_FULL: begin
                    if (rd_hit) begin
                        state_next = bank_release ? W_PP_EMPTY : W_PP_READING;
                    end
                end
                W_PP_READING: begin
                    if (rd_hit && bank_release) begin
                        state_next = W_PP_EMPTY;
                    end
                end
                default: state_next = W_PP_EMPTY;
            endcase
        end

        assign bank_empty[gi]    = (state_reg == W_PP_EMPTY);
        assign bank_writable[gi] = (state_reg == W_PP_EMPTY) || (state_reg == W_PP_FILLING);
        assign bank_readable[gi] = (state_reg == W_PP_FULL) || (state_reg == W_PP_READING);
        assign bank_ctrl[gi]     = ctrl_reg;

        redmule_w_pp_bank #(
            .DW     (DW),
            .BITW   (BITW),
            .HEIGHT (Height),
            .ROW_W  (ROW_W),
            .IDX_W  (IDX_W)
        ) i_bank (
            .clk_i     (clk_i),
            .we_i      (wr_hit),
            .row_i     (w_row_reg),
            .w_data_i  (w_data_i),
            .width_i   (wr_ctrl.width),
            .height_i  (wr_ctrl.height),
            .rd_idx_i  (rd_idx),
            .rd_data_o (bank_rd[gi])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            fill_reg      <= '0;
            rd_reg        <= '0;
            w_row_reg     <= '0;
            el_reg        <= '0;
            col_reg       <= '0;
            pass_reg      <= '0;
            bank_done_reg <= 1'b0;
        end else begin
            fill_reg      <= fill_next;
            rd_reg        <= rd_next;
            w_row_reg     <= w_row_next;
            el_reg        <= el_next;
            col_reg       <= col_next;
            pass_reg      <= pass_next;
            bank_done_reg <= bank_done_next;
        end
    end

    always_comb begin
        fill_next      = fill_reg;
        rd_next        = rd_reg;
        w_row_next     = w_row_reg;
        el_next        = el_reg;
        col_next       = col_reg;
        pass_next      = pass_reg;
        bank_done_next = 1'b0;

        if (wr_fire) begin
            if (row_last) begin
                w_row_next = '0;
                fill_next  = PW'(ring_next(32'(fill_reg), N_BANKS));
            end else begin
                w_row_next = w_row_reg + ROW_W'(1);
            end
        end

        if (sh_fire) begin
            if (el_reg == EL_W'(N_REGS)) begin
                el_next = '0;
                if (col_reg == COL_W'(C - 1)) begin
                    col_next = '0;
                end else begin
                    col_next = col_reg + COL_W'(1);
                end
            end else begin
                el_next = el_reg + EL_W'(1);
            end
            if (last_shift) begin
                if (bank_release) begin
                    pass_next      = '0;
                    rd_next        = PW'(ring_next(32'(rd_reg), N_BANKS));
                    bank_done_next = 1'b1;
                end else begin
                    pass_next = pass_reg + 8'd1;
                end
            end
        end
    end

    assign w_ready_o   = flags.w_ready;
    assign out_valid_o = flags.out_valid;
    assign bank_done_o = flags.bank_done;
    assign w_buffer_o  = flags.out_valid ? bank_rd[rd_reg] : '0;
    assign fill_bank_o = fill_reg;
    assign read_bank_o = rd_reg;

endmodule

// File: tb/tb_redmule_w_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for redmule_w_pingpong_buffer with default geometry
// (D = 18, H = 4, N_REGS = 3, NSH = 20, two banks). A tile-level model tracks
// how many complete tiles are waiting, the tile contents and the read position;
// expected output words go into a scoreboard queue that a separate monitor
// drains whenever the DUT accepts a shift.
// -----------------------------------------------------------------------------
module tb_redmule_w_pingpong_buffer;

    localparam int DW   = 288;
    localparam int BITW = 16;
    localparam int H    = 4;
    localparam int NR   = 3;
    localparam int NB   = 2;
    localparam int D    = DW / BITW;
    localparam int NSH  = ((D + NR) / (NR + 1)) * (NR + 1);
    localparam int OW   = H * BITW;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            clear_i;
    logic            w_valid_i;
    logic            w_ready_o;
    logic [DW-1:0]   w_data_i;
    logic [5:0]      width_i;
    logic [2:0]      height_i;
    logic [7:0]      reps_i;
    logic            shift_i;
    logic            out_valid_o;
    logic [OW-1:0]   w_buffer_o;
    logic            bank_done_o;
    logic [0:0]      fill_bank_o;
    logic [0:0]      read_bank_o;

    redmule_w_pingpong_buffer #(
        .DW      (DW),
        .BITW    (BITW),
        .Height  (H),
        .N_REGS  (NR),
        .N_BANKS (NB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .w_valid_i   (w_valid_i),
        .w_ready_o   (w_ready_o),
        .w_data_i    (w_data_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .reps_i      (reps_i),
        .shift_i     (shift_i),
        .out_valid_o (out_valid_o),
        .w_buffer_o  (w_buffer_o),
        .bank_done_o (bank_done_o),
        .fill_bank_o (fill_bank_o),
        .read_bank_o (read_bank_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // ---------------- tile-level reference model ----------------
    logic [15:0] m_mem [NB][H][D];
    int  m_w [NB];
    int  m_h [NB];
    int  m_reps [NB];
    int  m_count, m_fill, m_rd, m_row, m_shift;
    bit  m_done;
    int  cur_w, cur_h, cur_reps;
    bit  all_ones, rand_mode;
    logic [OW-1:0] sb_q [$];
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_fill = 0; m_rd = 0; m_row = 0; m_shift = 0; m_done = 0;
    endtask

    function automatic int eff_reps(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    // One clock cycle: drive, check the combinational view against the model,
    // queue the expected output word, then advance the model past the edge.
    task automatic cycle(input bit v_in, input bit s_in, input bit clr);
        bit exp_ready, exp_valid, wr, sh, fin_fill, fin_read, v, s;
        int lw, lh, idx;
        logic [OW-1:0] ew;
        v = clr ? 1'b0 : v_in;
        s = clr ? 1'b0 : s_in;
        @(posedge clk_i);
        #1;
        if (rand_mode && m_row == 0) begin
            cur_w    = $urandom_range(1, D);
            cur_h    = $urandom_range(1, H);
            cur_reps = $urandom_range(0, 3);
        end
        clear_i   = clr;
        w_valid_i = v;
        shift_i   = s;
        for (int d = 0; d < D; d++) begin
            w_data_i[d*BITW +: BITW] = all_ones ? 16'hFFFF : 16'($urandom);
        end
        if (m_row == 0) begin
            width_i  = 6'(cur_w);
            height_i = 3'(cur_h);
            reps_i   = 8'(cur_reps);
        end else begin
            // Later rows carry junk shape values; only the first row's count.
            width_i  = 6'($urandom_range(0, D));
            height_i = 3'($urandom_range(0, H));
            reps_i   = 8'($urandom_range(0, 7));
        end
        exp_ready = (m_count < NB);
        exp_valid = (m_count > 0);
        #2;
        chk("w_ready", w_ready_o, exp_ready);
        chk("out_valid", out_valid_o, exp_valid);
        chk("bank_done", bank_done_o, m_done);
        chk("fill_bank", fill_bank_o, m_fill);
        chk("read_bank", read_bank_o, m_rd);
        if (!exp_valid) chk("w_buffer_idle", w_buffer_o, '0);
        if (m_done) $display("bank released: now reading bank %0d", m_rd);

        m_done   = 0;
        fin_fill = 0;
        fin_read = 0;
        wr = v && exp_ready;
        sh = s && exp_valid;
        if (sh) begin
            idx = m_shift % NSH;
            for (int h = 0; h < H; h++) begin
                ew[h*BITW +: BITW] = (idx < D) ? m_mem[m_rd][h][idx] : 16'h0;
            end
            sb_q.push_back(ew);
            m_shift++;
            if (m_shift == NSH * eff_reps(m_reps[m_rd])) fin_read = 1;
        end
        if (wr) begin
            if (m_row == 0) begin
                m_w[m_fill]    = cur_w;
                m_h[m_fill]    = cur_h;
                m_reps[m_fill] = cur_reps;
            end
            lw = m_w[m_fill];
            lh = m_h[m_fill];
            for (int d = 0; d < D; d++) begin
                m_mem[m_fill][m_row][d] = (d < lw && m_row < lh) ? w_data_i[d*BITW +: BITW] : 16'h0;
            end
            m_row++;
            if (m_row == H) begin
                m_row = 0;
                fin_fill = 1;
            end
        end
        if (fin_read) begin
            m_count--;
            m_rd = (m_rd + 1) % NB;
            m_shift = 0;
            m_done = 1;
        end
        if (fin_fill) begin
            m_count++;
            m_fill = (m_fill + 1) % NB;
        end
        if (clr) model_reset();
    endtask

    // Monitor: whenever the DUT takes a shift, its current output must match
    // the oldest queued expectation.
    always @(negedge clk_i) begin
        if (mon_en && !rst_i && shift_i && out_valid_o) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL w_buffer_unexpected: got %0h expected no shift at %0t", w_buffer_o, $time);
            end else begin
                logic [OW-1:0] e;
                e = sb_q.pop_front();
                if (w_buffer_o !== e) begin
                    bad++;
                    $display("FAIL w_buffer: got %0h expected %0h at %0t", w_buffer_o, e, $time);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; w_valid_i = 1'b0; shift_i = 1'b0;
        w_data_i = '0; width_i = '0; height_i = '0; reps_i = '0;
        all_ones = 0; rand_mode = 0;
        cur_w = D; cur_h = H; cur_reps = 1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        mon_en = 1'b1;

        // shift held with nothing stored: must be ignored
        repeat (3) cycle(0, 1, 0);

        // full tile, single pass
        repeat (4) cycle(1, 0, 0);
        repeat (22) cycle(0, 1, 0);

        // 5x2 all-ones tile: padding rows and columns read zero
        all_ones = 1; cur_w = 5; cur_h = 2;
        repeat (4) cycle(1, 0, 0);
        repeat (22) cycle(0, 1, 0);

        // three passes over one bank
        all_ones = 0; cur_w = D; cur_h = H; cur_reps = 3;
        repeat (4) cycle(1, 0, 0);
        repeat (62) cycle(0, 1, 0);

        // ping-pong: fill both banks, stall, then stream with reads
        cur_reps = 1;
        repeat (12) cycle(1, 0, 0);
        repeat (60) cycle(1, 1, 0);
        repeat (60) cycle(0, 1, 0);

        // soft clear mid-fill and mid-read
        cycle(0, 0, 1);
        repeat (2) cycle(1, 0, 0);
        cycle(0, 0, 1);
        repeat (2) cycle(0, 0, 0);
        repeat (4) cycle(1, 0, 0);
        repeat (7) cycle(0, 1, 0);
        cycle(0, 0, 1);
        repeat (3) cycle(0, 1, 0);

        // randomized traffic with random tile shapes and occasional clears
        rand_mode = 1;
        for (int i = 0; i < 900; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        rand_mode = 0;
        repeat (150) cycle(0, 1, 0);

        @(posedge clk_i);
        #3;
        chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redmule_w_pingpong_buffer.md
# redmule_w_pingpong_buffer

Next-generation weight buffer for the RedMulE datapath. It stores W tiles in `N_BANKS` ring-ordered banks, so one bank can be filled from the streamer while another feeds the PE array. Each row is zero-padded to the programmed tile width and height. A bank can be replayed a programmable number of times before it is released. The block sits between the W streamer FIFO and the engine's W broadcast inputs, and replaces the single-bank buffer.

## Interface
- `DW`, 288: input row width in bits.
- `BITW`, 16: element width in bits. Equal to `fp_width(FpFormat)`.
- `Height`, `ARRAY_HEIGHT`: number of rows per bank (`H`).
- `N_REGS`, `PIPE_REGS`: pipeline registers per PE. Elements per column group = `N_REGS+1`.
- `N_BANKS`, 2: number of banks. Must be ≥2.
- Derived: `D = DW/BITW`; `C = ceil(D/(N_REGS+1))`; `NSH = C*(N_REGS+1)`, the number of shifts per bank pass.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `clear_i`, in, 1: synchronous soft clear of all control state.
- `w_valid_i`, in, 1: an input row is valid.
- `w_ready_o`, out, 1: the buffer accepts a row.
- `w_data_i`, in, `DW`: row data. Element `d` = bits `[(d+1)*BITW-1:d*BITW]`.
- `width_i`, in, `$clog2(D)+1`: number of valid elements per row.
- `height_i`, in, `$clog2(H)+1`: number of valid rows in the tile.
- `reps_i`, in, 8: number of read passes per bank. 0 is treated as 1.
- `shift_i`, in, 1: consume the current output column element.
- `out_valid_o`, out, 1: `w_buffer_o` holds valid data.
- `w_buffer_o`, out, `H*BITW`: one element per row, for the current read bank.
- `bank_done_o`, out, 1: one-cycle pulse when a bank is released.
- `fill_bank_o`, out, `$clog2(N_BANKS)`: index of the bank being written.
- `read_bank_o`, out, `$clog2(N_BANKS)`: index of the bank being read.

## Operation
- Each bank has a state:
  - EMPTY → FILLING when it accepts its first row.
  - FILLING → FULL when it accepts row `H-1`.
  - FULL → READING on the first accepted shift.
  - READING → EMPTY after pass `reps` completes.
- Write side:
  - `w_ready_o` = fill bank is EMPTY or FILLING.
  - A row transfers when `w_valid_i && w_ready_o`. It is written to row `w_row` of the fill bank, then `w_row` increments.
  - `width_i`, `height_i` and `reps_i` are latched into the bank on its first row.
  - Stored element `[r][d]` = input element `d` if `d < width_q && r < height_q`, else 0.
  - After row `H-1`, `w_row` returns to 0 and the fill pointer advances to `(fill+1) mod N_BANKS`.
- Read side:
  - `out_valid_o` = read bank is FULL or READING.
  - `w_buffer_o[h]` = `bank[rd][h][col*(N_REGS+1)+el]`. The value is 0 when the index is ≥ `D` or when `out_valid_o = 0`.
  - An accepted shift is `shift_i && out_valid_o`. `shift_i` while `!out_valid_o` is ignored.
  - On an accepted shift: `el` wraps from `N_REGS` to 0. On that wrap, `col` increments and wraps from `C-1` to 0.
  - When `col` and `el` both wrap, the pass counter increments. If pass = `reps`, the bank becomes EMPTY, `bank_done_o` pulses, the pass counter clears, and the read pointer advances modulo `N_BANKS`.
- Fill and read of different banks proceed concurrently.
- When `fill == rd`, the bank cannot be written until it is EMPTY.
- `clear_i` and `rst_i` return all banks to EMPTY and zero all pointers and counters. Stored data is not cleared.

## Timing
- Reset values: `w_ready_o = 1`, `out_valid_o = 0`, `w_buffer_o = 0`, `bank_done_o = 0`, `fill_bank_o = 0`, `read_bank_o = 0`.
- A bank completed by the row accepted at edge k has `out_valid_o = 1` from cycle k+1.
- `w_buffer_o` is a combinational read of the registered storage and counters. It updates in the cycle after an accepted shift.
- Simultaneous final shift of bank A and first row into bank A when `N_BANKS = 2` and `fill == A`: `w_ready_o` is 0 in that cycle, so the row is not accepted. It is accepted no earlier than the next cycle.
- Simultaneous final write row and shift on different banks: both take effect.
- `rst_i` or `clear_i` mid-fill or mid-read: state is EMPTY the following cycle. A partially filled bank is discarded, and no `bank_done_o` is emitted.
- `bank_done_o` is asserted in the cycle after the final accepted shift, for exactly one cycle.

## Structure
- `redmule_pkg` additions:
  - `w_pp_bank_state_e` (EMPTY, FILLING, FULL, READING).
  - `w_pp_ctrl_t`, bundling `width`, `height`, `reps`.
  - `w_pp_flags_t`, bundling `w_ready`, `out_valid`, `bank_done`.
- Sub-module `redmule_w_pp_bank`: one bank's latch/flop array. Provides a row write with zero-pad masks and a column-element read mux. Instantiated `N_BANKS` times.
- Pointers, counters and the per-bank FSMs live in the top module.

## Test plan
- Defaults (`D = 18`, `H = 4`, `N_REGS = 3`, `C = 5`, `NSH = 20`), `width = 18`, `height = 4`, `reps = 1`, four rows, then 20 shifts:
  - `out_valid_o` rises one cycle after the 4th row.
  - Outputs match the rows in column order; elements 18–19 read 0.
  - `bank_done_o` pulses once; `read_bank_o` becomes 1.
- `width = 5`, `height = 2` with all-ones rows: rows 2–3 read 0; elements ≥5 read 0.
- `reps = 3`: 60 shifts before `bank_done_o`, and the output sequence repeats identically three times.
- Ping-pong streaming: bank 1 is filled during bank 0's read with no stalls. `w_ready_o` drops after 8 rows, until bank 0 is released, and recovers the cycle after `bank_done_o`.
- `clear_i` asserted after 2 rows and after 7 shifts: next cycle `w_ready_o = 1`, `out_valid_o = 0`, pointers 0, and no `bank_done_o`.
- `shift_i` held high with all banks empty: no counter movement and `w_buffer_o = 0`.
